// File: rtl/ct_f_spsram_64x108_ctrl.sv
// Front-end controller for the 64x108 single-port SRAM wrapper.
// Zero-clears the array after every reset, then serves one valid/ready
// read-or-write request per cycle. Read data is returned in order through a
// 2-entry response FIFO with backpressure.
module ct_f_spsram_64x108_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int LANE_WIDTH = 27,
  parameter int LANES      = 4
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              req_vld,
  output logic                              req_rdy,
  input  logic                              req_wr,
  input  logic [ADDR_WIDTH-1:0]             req_addr,
  input  logic [LANES*LANE_WIDTH-1:0]       req_wdata,
  input  logic [LANES-1:0]                  req_wmask,
  output logic                              rsp_vld,
  input  logic                              rsp_rdy,
  output logic [LANES*LANE_WIDTH-1:0]       rsp_rdata,
  output logic                              init_done,
  output logic [ADDR_WIDTH-1:0]             sram_A,
  output logic                              sram_CEN,
  output logic                              sram_GWEN,
  output logic [LANES*LANE_WIDTH-1:0]       sram_WEN,
  output logic [LANES*LANE_WIDTH-1:0]       sram_D,
  input  logic [LANES*LANE_WIDTH-1:0]       sram_Q
);

  localparam int DW = LANES * LANE_WIDTH;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] init_cnt;

  logic                  accept;
  logic                  rd_inflight;
  logic                  push;
  logic                  pop;
  logic [1:0]            rsp_cnt;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [DW-1:0]         rbuf [2];
  logic [2:0]            occ;
  logic [DW-1:0]         wen_req;

  // Clear sequencer: one zero-write per cycle, then RUN until the next reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (&init_cnt) begin
        state     <= ST_RUN;
        init_done <= 1'b1;
      end
    end
  end

  // Occupancy counts reads already in the SRAM pipe, so an accepted read
  // always has a FIFO slot waiting when its Q arrives.
  always_comb begin
    occ     = {1'b0, rsp_cnt} + {2'b00, rd_inflight} - {2'b00, pop};
    req_rdy = (state == ST_RUN) && (occ < 3'd2);
    accept  = req_vld && req_rdy;
  end

  // Per-lane write mask expanded into active-low per-bit WEN.
  always_comb begin
    wen_req = '1;
    for (int k = 0; k < LANES; k++)
      wen_req[k*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{~req_wmask[k]}};
  end

  // SRAM pins: held inactive in reset, clear pattern in INIT, request in RUN.
  always_comb begin
    sram_CEN  = 1'b1;
    sram_GWEN = 1'b1;
    sram_WEN  = '1;
    sram_A    = req_addr;
    sram_D    = req_wdata;
    if (RST) begin
      sram_CEN = 1'b1;
    end else if (state == ST_INIT) begin
      sram_CEN  = 1'b0;
      sram_GWEN = 1'b0;
      sram_WEN  = '0;
      sram_D    = '0;
      sram_A    = init_cnt;
    end else if (accept) begin
      sram_CEN = 1'b0;
      if (req_wr) begin
        sram_GWEN = 1'b0;
        sram_WEN  = wen_req;
      end
    end
  end

  // Q is only meaningful the cycle after a read was issued.
  always_comb begin
    push = rd_inflight;
    pop  = (rsp_cnt != 2'd0) && rsp_rdy;
  end

  // Response FIFO and read-in-flight tracking.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_inflight <= 1'b0;
      rsp_cnt     <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      rbuf[0]     <= '0;
      rbuf[1]     <= '0;
    end else begin
      rd_inflight <= accept && !req_wr;
      if (push) begin
        rbuf[wr_ptr] <= sram_Q;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   rsp_cnt <= rsp_cnt + 2'd1;
        2'b01:   rsp_cnt <= rsp_cnt - 2'd1;
        default: rsp_cnt <= rsp_cnt;
      endcase
    end
  end

  // Head of the FIFO is presented directly; it only moves on a pop.
  always_comb begin
    rsp_vld   = (rsp_cnt != 2'd0);
    rsp_rdata = rbuf[rd_ptr];
  end

endmodule

// File: tb/tb_ct_f_spsram_64x108_ctrl.sv
// Directed bench for ct_f_spsram_64x108_ctrl with a behavioural SRAM model.
module tb_ct_f_spsram_64x108_ctrl;

  localparam int DW = 108;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          req_vld, req_rdy, req_wr;
  logic [5:0]    req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_wmask;
  logic          rsp_vld, rsp_rdy;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic [5:0]    sram_A;
  logic          sram_CEN, sram_GWEN;
  logic [DW-1:0] sram_WEN, sram_D, sram_Q;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [DW-1:0] ONES  = {DW{1'b1}};
  localparam logic [DW-1:0] D2    = 108'h0_1234_5678_9ABC_DEF0_1357_9BDF;
  localparam logic [DW-1:0] LANE_0101 = {27'h7FF_FFFF, 27'h0, 27'h7FF_FFFF, 27'h0};

  ct_f_spsram_64x108_ctrl dut (
    .CLK(CLK), .RST(RST),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .sram_A(sram_A), .sram_CEN(sram_CEN), .sram_GWEN(sram_GWEN),
    .sram_WEN(sram_WEN), .sram_D(sram_D), .sram_Q(sram_Q)
  );

  always #5 CLK = ~CLK;

  // SRAM model: Q registered on reads, garbage on any other cycle.
  logic [DW-1:0] mem [64];
  logic [127:0]  junk;
  always @(posedge CLK) begin
    junk = {$urandom, $urandom, $urandom, $urandom};
    if (!sram_CEN && sram_GWEN)
      sram_Q <= mem[sram_A];
    else
      sram_Q <= junk[DW-1:0];
    if (!sram_CEN && !sram_GWEN)
      mem[sram_A] <= (mem[sram_A] & sram_WEN) | (sram_D & ~sram_WEN);
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle;
    req_vld = 0; req_wr = 0; req_addr = '0; req_wdata = '0; req_wmask = '0;
  endtask

  // Walk n clear cycles, checking the pins each cycle.
  task automatic init_walk(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      chk("init_A", DW'(sram_A), DW'(i));
      chk("init_ctl", {sram_CEN, sram_GWEN, req_rdy, init_done}, '0);
      chk("init_wen_d", DW'(|{sram_WEN, sram_D}), '0);
      step;
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [DW-1:0] d, input logic [3:0] m,
                    input logic [DW-1:0] exp_wen);
    req_vld = 1; req_wr = 1; req_addr = a; req_wdata = d; req_wmask = m;
    #1;
    chk("wr_rdy", DW'(req_rdy), 1);
    chk("wr_pins", {sram_CEN, sram_GWEN, sram_A}, {2'b00, a});
    chk("wr_wen", sram_WEN, exp_wen);
    step;
    idle;
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] a, input logic [DW-1:0] exp);
    req_vld = 1; req_wr = 0; req_addr = a; rsp_rdy = 1;
    #1;
    chk({tag, "_rdy"}, DW'(req_rdy), 1);
    chk({tag, "_pins"}, {sram_CEN, sram_GWEN, (&sram_WEN)}, 3'b011);
    step;
    idle;
    #1;
    chk({tag, "_lat1"}, DW'(rsp_vld), 0);
    step;
    #1;
    chk({tag, "_vld"}, DW'(rsp_vld), 1);
    chk({tag, "_data"}, rsp_rdata, exp);
    step;
  endtask

  logic [DW-1:0] d4 [8];

  initial begin
    for (int i = 0; i < 64; i++) begin
      junk = {$urandom, $urandom, $urandom, $urandom};
      mem[i] = junk[DW-1:0];
    end
    idle;
    rsp_rdy = 1;

    // 1: reset state, clear sequence, init_done timing
    step;
    #1;
    chk("rst_ctl", {sram_CEN, sram_GWEN, init_done, req_rdy, rsp_vld}, 5'b11000);
    chk("rst_wen", sram_WEN, ONES);
    chk("rst_rdata", rsp_rdata, '0);
    step;
    RST = 0;
    init_walk(64);
    #1;
    chk("init_done", DW'(init_done), 1);
    chk("run_rdy", DW'(req_rdy), 1);
    chk("run_idle_pins", {sram_CEN, sram_GWEN, (&sram_WEN)}, 3'b111);
    chk("mem_cleared", mem[63] | mem[0], '0);
    step;

    // 2: write then read-after-write
    wr(6'd5, D2, 4'hF, '0);
    rd_chk("raw", 6'd5, D2);

    // 3: lane masking
    wr(6'd9, ONES, 4'hF, '0);
    wr(6'd9, '0, 4'h5, LANE_0101);
    rd_chk("mask", 6'd9, LANE_0101);

    // empty mask write: accepted but nothing changes
    wr(6'd9, '0, 4'h0, ONES);
    rd_chk("mask0", 6'd9, LANE_0101);

    // 4: back-to-back reads
    for (int i = 0; i < 8; i++) begin
      d4[i] = {27'(i) + 27'h100, 27'h5A5_A5A5 ^ 27'(i), 27'(i * 3), 27'h700_0000 | 27'(i)};
      wr(6'(i), d4[i], 4'hF, '0);
    end
    rsp_rdy = 1;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        req_vld = 1; req_wr = 0; req_addr = 6'(c);
      end else
        idle;
      #1;
      if (c < 8) chk("b2b_rdy", DW'(req_rdy), 1);
      if (c >= 2) begin
        chk("b2b_vld", DW'(rsp_vld), 1);
        chk("b2b_data", rsp_rdata, d4[c-2]);
      end
      step;
    end
    #1;
    chk("b2b_empty", DW'(rsp_vld), 0);
    step;

    // 5: backpressure
    rsp_rdy = 0;
    req_vld = 1; req_wr = 0; req_addr = 6'd3;
    #1; chk("bp_rdy0", DW'(req_rdy), 1); step;
    req_addr = 6'd4;
    #1; chk("bp_rdy1", DW'(req_rdy), 1); step;
    req_addr = 6'd5;
    #1; chk("bp_rdy2", DW'(req_rdy), 0); step;
    #1; chk("bp_rdy3", DW'(req_rdy), 0);
    chk("bp_head", rsp_rdata, d4[3]);
    step;
    #1; chk("bp_hold", {rsp_vld, rsp_rdata}, {1'b1, d4[3]});
    chk("bp_rdy4", DW'(req_rdy), 0);
    step;
    idle;
    rsp_rdy = 1;
    #1; chk("bp_drain0", {rsp_vld, rsp_rdata}, {1'b1, d4[3]});
    chk("bp_rdy_back", DW'(req_rdy), 1);
    step;
    #1; chk("bp_drain1", {rsp_vld, rsp_rdata}, {1'b1, d4[4]});
    step;
    #1; chk("bp_drained", DW'(rsp_vld), 0);
    step;

    // 6: reset with two buffered responses, then mid-init reset
    rsp_rdy = 0;
    req_vld = 1; req_wr = 0; req_addr = 6'd1; step;
    req_addr = 6'd2; step;
    idle; step;
    #1; chk("pre_rst_full", {rsp_vld, req_rdy}, 2'b10);
    RST = 1;
    #1;
    chk("rst_vld", {rsp_vld, req_rdy, init_done, sram_CEN}, 4'b0001);
    chk("rst_rdata2", rsp_rdata, '0);
    step;
    RST = 0;
    rsp_rdy = 1;
    init_walk(30);
    #1; chk("mid_A30", DW'(sram_A), 30);
    RST = 1;
    #1; chk("mid_rst", {sram_CEN, sram_GWEN, init_done}, 3'b110);
    step;
    RST = 0;
    init_walk(64);
    #1; chk("reinit_done", DW'(init_done), 1);
    step;
    rd_chk("clr5", 6'd5, '0);
    rd_chk("clr9", 6'd9, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
